// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit and its HI/LO
// register file: operation encodings, sequencer state encodings and the
// default operand width.
// Optional build macro used by the files of this block: MULDIV_DIV0_FLAG_EN
// (adds a div0 flag and a fast divide-by-zero path).
// -----------------------------------------------------------------------------
package muldiv_pkg;

   // Default operand width; HI and LO are each this wide.
   localparam int DEF_DATA_WIDTH = 32;

   // Operation select encodings.
   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   // Sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Pipeline <-> multiply/divide unit bundle.
//   master (pipeline side): drives start, op, rs_data, rt_data, mthi, mtlo,
//                           mt_data, hilo_rd; observes hi, lo, busy, done,
//                           stall (and div0 when MULDIV_DIV0_FLAG_EN is set).
//   slave  (unit side)    : the mirror image.
// Build macro: MULDIV_DIV0_FLAG_EN adds the div0 signal.
// -----------------------------------------------------------------------------
interface muldiv_if import muldiv_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int OP_WIDTH   = 2
);
   logic                  start;
   logic [OP_WIDTH-1:0]   op;
   logic [DATA_WIDTH-1:0] rs_data;
   logic [DATA_WIDTH-1:0] rt_data;
   logic                  mthi;
   logic                  mtlo;
   logic [DATA_WIDTH-1:0] mt_data;
   logic                  hilo_rd;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;
   logic                  busy;
   logic                  done;
   logic                  stall;
`ifdef MULDIV_DIV0_FLAG_EN
   logic                  div0;
`endif

   modport master (
      output start, op, rs_data, rt_data, mthi, mtlo, mt_data, hilo_rd,
      input  hi, lo, busy, done, stall
`ifdef MULDIV_DIV0_FLAG_EN
      , input div0
`endif
   );

   modport slave (
      input  start, op, rs_data, rt_data, mthi, mtlo, mt_data, hilo_rd,
      output hi, lo, busy, done, stall
`ifdef MULDIV_DIV0_FLAG_EN
      , output div0
`endif
   );

endinterface

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the unsigned engine.
//   mode     : 0 = shift-add multiply, 1 = restoring divide
//   acc      : partial product high half / partial remainder
//   sreg     : multiplier being consumed (LSB first) / dividend being consumed
//              (MSB first) while quotient bits shift in at the bottom
//   opnd     : multiplicand / divisor magnitude
//   acc_nxt, sreg_nxt : values after this iteration
// After DATA_WIDTH iterations {acc,sreg} is the product, or acc is the
// remainder and sreg the quotient.
// -----------------------------------------------------------------------------
module muldiv_step import muldiv_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  mode,
   input  logic [DATA_WIDTH-1:0] acc,
   input  logic [DATA_WIDTH-1:0] sreg,
   input  logic [DATA_WIDTH-1:0] opnd,
   output logic [DATA_WIDTH-1:0] acc_nxt,
   output logic [DATA_WIDTH-1:0] sreg_nxt
);

   logic [DATA_WIDTH:0]   sum_s;
   logic [DATA_WIDTH:0]   rem_sh_s;
   logic [DATA_WIDTH-1:0] diff_s;
   logic                  ge_s;

   // Single multiply or divide iteration.
   always_comb begin
      // Multiply: conditionally add, keeping the carry so the right shift
      // brings it back into the accumulator MSB.
      sum_s    = {1'b0, acc} + {1'b0, (sreg[0] ? opnd : {DATA_WIDTH{1'b0}})};
      // Divide: shift the next dividend bit into the partial remainder.
      rem_sh_s = {acc, sreg[DATA_WIDTH-1]};
      ge_s     = (rem_sh_s >= {1'b0, opnd});
      // When ge_s holds the difference is below the divisor, so the low
      // bits of the subtraction are the full result.
      diff_s   = rem_sh_s[DATA_WIDTH-1:0] - opnd;
      if (mode) begin
         acc_nxt  = ge_s ? diff_s : rem_sh_s[DATA_WIDTH-1:0];
         sreg_nxt = {sreg[DATA_WIDTH-2:0], ge_s};
      end else begin
         acc_nxt  = sum_s[DATA_WIDTH:1];
         sreg_nxt = {sum_s[0], sreg[DATA_WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative multiply/divide unit and owner of the HI/LO registers.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : muldiv_if.slave -- start/op/rs_data/rt_data request, mthi/mtlo/
//          mt_data writes, hilo_rd read indication; hi/lo/busy/done/stall
//          (and div0) back to the pipeline.
// Operands are reduced to magnitudes at start, the unsigned engine runs
// DATA_WIDTH steps (CALC), FIX applies the stored signs and writes HI/LO, and
// DONE pulses done for one cycle.
// Build macro: MULDIV_DIV0_FLAG_EN -- DIV/DIVU by zero skips CALC, leaves
// HI/LO untouched and pulses div0 together with done.
// -----------------------------------------------------------------------------
module muldiv_sequencer import muldiv_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int OP_WIDTH   = 2,
   parameter int CNT_WIDTH  = 6
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_CALC = CALC;
   localparam logic [1:0] ST_FIX  = FIX;
   localparam logic [1:0] ST_DONE = DONE;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]              state_r;
   logic [1:0]              state_nxt_s;
   logic [CNT_WIDTH-1:0]    cnt_r;
   logic [DATA_WIDTH-1:0]   acc_r;
   logic [DATA_WIDTH-1:0]   sreg_r;
   logic [DATA_WIDTH-1:0]   opnd_r;
   logic [DATA_WIDTH-1:0]   acc_nxt_s;
   logic [DATA_WIDTH-1:0]   sreg_nxt_s;
   logic                    div_r;
   logic                    neg_q_r;
   logic                    neg_r_r;
   logic [DATA_WIDTH-1:0]   hi_r;
   logic [DATA_WIDTH-1:0]   lo_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    accept_s;
   logic                    is_div_s;
   logic                    is_signed_s;
   logic                    a_neg_s;
   logic                    b_neg_s;
   logic                    mt_ok_s;
   logic [2*DATA_WIDTH-1:0] prod_fix_s;
   logic [DATA_WIDTH-1:0]   quo_fix_s;
   logic [DATA_WIDTH-1:0]   rem_fix_s;
`ifdef MULDIV_DIV0_FLAG_EN
   logic                    div0_r;
   logic                    div0_hit_s;
`endif

   // Two's-complement negate when neg is set (magnitude or sign restore).
   function automatic logic [DATA_WIDTH-1:0] apply_sign(
      input logic [DATA_WIDTH-1:0] v,
      input logic                  neg
   );
      apply_sign = neg ? (~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : v;
   endfunction

   // Request decode and acceptance window.
   always_comb begin
      is_div_s    = (bus.op == OP_WIDTH'(OP_DIV))  | (bus.op == OP_WIDTH'(OP_DIVU));
      is_signed_s = (bus.op == OP_WIDTH'(OP_MULT)) | (bus.op == OP_WIDTH'(OP_DIV));
      a_neg_s     = is_signed_s & bus.rs_data[DATA_WIDTH-1];
      // A zero divisor is never negative, so it is treated as positive.
      b_neg_s     = is_signed_s & bus.rt_data[DATA_WIDTH-1];
      // DONE accepts requests like IDLE because stall is released there.
      mt_ok_s     = (state_r == ST_IDLE) | (state_r == ST_DONE);
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0_hit_s  = 1'b0;
`endif
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               accept_s = 1'b1;
`ifdef MULDIV_DIV0_FLAG_EN
               if (is_div_s && (bus.rt_data == {DATA_WIDTH{1'b0}})) begin
                  state_nxt_s = ST_DONE;
                  div0_hit_s  = 1'b1;
               end else begin
                  state_nxt_s = ST_CALC;
               end
`else
               state_nxt_s = ST_CALC;
`endif
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (cnt_r == CNT_LAST) begin
               state_nxt_s = ST_FIX;
            end else begin
               state_nxt_s = ST_CALC;
            end
         end
         ST_FIX:  state_nxt_s = ST_DONE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Sign correction of the unsigned engine result.
   always_comb begin
      if (neg_q_r) begin
         prod_fix_s = ~{acc_r, sreg_r} + {{(2*DATA_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         prod_fix_s = {acc_r, sreg_r};
      end
      quo_fix_s = apply_sign(sreg_r, neg_q_r);
      rem_fix_s = apply_sign(acc_r, neg_r_r);
   end

   muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .mode     (div_r),
      .acc      (acc_r),
      .sreg     (sreg_r),
      .opnd     (opnd_r),
      .acc_nxt  (acc_nxt_s),
      .sreg_nxt (sreg_nxt_s)
   );

   // State, iteration counter and registered busy/done flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CNT_WIDTH{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         done_r  <= (state_nxt_s == ST_DONE);
         if (accept_s) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
         end else if (state_r == ST_CALC) begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   // Engine registers: latch magnitudes and signs at start, iterate in CALC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r   <= {DATA_WIDTH{1'b0}};
         sreg_r  <= {DATA_WIDTH{1'b0}};
         opnd_r  <= {DATA_WIDTH{1'b0}};
         div_r   <= 1'b0;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
      end else if (accept_s) begin
         acc_r   <= {DATA_WIDTH{1'b0}};
         sreg_r  <= apply_sign(bus.rs_data, a_neg_s);
         opnd_r  <= apply_sign(bus.rt_data, b_neg_s);
         div_r   <= is_div_s;
         neg_q_r <= a_neg_s ^ b_neg_s;
         neg_r_r <= a_neg_s;
      end else if (state_r == ST_CALC) begin
         acc_r   <= acc_nxt_s;
         sreg_r  <= sreg_nxt_s;
      end
   end

   // HI/LO: results from FIX, MTHI/MTLO when idle; start drops MT writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_r <= {DATA_WIDTH{1'b0}};
         lo_r <= {DATA_WIDTH{1'b0}};
      end else if (state_r == ST_FIX) begin
         if (div_r) begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
         end else begin
            {hi_r, lo_r} <= prod_fix_s;
         end
      end else if (mt_ok_s && !bus.start) begin
         if (bus.mthi) begin
            hi_r <= bus.mt_data;
         end
         if (bus.mtlo) begin
            lo_r <= bus.mt_data;
         end
      end
   end

`ifdef MULDIV_DIV0_FLAG_EN
   // Divide-by-zero flag, aligned with the done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div0_r <= 1'b0;
      end else begin
         div0_r <= div0_hit_s;
      end
   end

   assign bus.div0 = div0_r;
`endif

   assign bus.hi    = hi_r;
   assign bus.lo    = lo_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   // Hold any unit/HI-LO request while in flight; DONE lets it through.
   assign bus.stall = busy_r & (bus.start | bus.mthi | bus.mtlo | bus.hilo_rd) & ~done_r;

endmodule
